// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side and FIFO-write-side signals of the write arbiter.
//   req0/din0, req1/din1 : producer requests and data, held until the matching grant
//   data_count           : FIFO occupancy, 0..DEPTH
//   gnt0/gnt1            : 1-cycle accept pulses back to the producers
//   wr_en/din            : FIFO write port
//   arb_state            : arbiter FSM state, for debug
// master = the arbiter, slave = the environment (producers plus FIFO).
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 4
);
    logic                  req0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] din1;
    logic [CNT_WIDTH-1:0]  data_count;
    logic                  gnt0;
    logic                  gnt1;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic [1:0]            arb_state;

    modport master (
        input  req0, din0, req1, din1, data_count,
        output gnt0, gnt1, wr_en, din, arb_state
    );

    modport slave (
        output req0, din0, req1, din1, data_count,
        input  gnt0, gnt1, wr_en, din, arb_state
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between two producers.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous reset, active-high
//   err_cnt  : saturating count of cycles spent in FULL_WAIT (only with FIFO_ARB_ERRCNT_EN)
//   bus      : fifo_wr_arbiter_if master modport (requests, data_count, grants, write port)
// Optional feature macro: FIFO_ARB_ERRCNT_EN adds the err_cnt output and its counter.
// All outputs are decoded from registered state, so they change only at the clock edge.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FIFO_ARB_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    fifo_wr_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StGnt0     = 2'b01,
        StGnt1     = 2'b10,
        StFullWait = 2'b11
    } state_e;

    localparam logic [CNT_WIDTH:0] DEPTH_CNT = (CNT_WIDTH + 1)'(DEPTH);

    state_e                state_q, state_d;
    logic                  last_gnt_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  granting;
    logic                  e0, e1;
    logic [CNT_WIDTH:0]    eff;
    logic                  full;

    assign granting = (state_q == StGnt0) || (state_q == StGnt1);

    // A producer being granted this cycle still holds its old word; mask it.
    assign e0 = bus.req0 && (state_q != StGnt0);
    assign e1 = bus.req1 && (state_q != StGnt1);

    // The write issued this cycle is not yet in data_count.
    assign eff  = {1'b0, bus.data_count} + {{CNT_WIDTH{1'b0}}, granting};
    // >= also treats an out-of-range data_count as full.
    assign full = (eff >= DEPTH_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            din_q      <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_d)
                StGnt0: begin
                    last_gnt_q <= 1'b0;
                    din_q      <= bus.din0;
                end
                StGnt1: begin
                    last_gnt_q <= 1'b1;
                    din_q      <= bus.din1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StIdle;
        if ((e0 || e1) && full) begin
            state_d = StFullWait;
        end else if (e0 && e1) begin
            state_d = last_gnt_q ? StGnt0 : StGnt1;
        end else if (e0) begin
            state_d = StGnt0;
        end else if (e1) begin
            state_d = StGnt1;
        end
    end

    // Output decode
    always_comb begin
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.wr_en     = 1'b0;
        bus.din       = din_q;
        bus.arb_state = state_q;
        unique case (state_q)
            StGnt0: begin
                bus.gnt0  = 1'b1;
                bus.wr_en = 1'b1;
            end
            StGnt1: begin
                bus.gnt1  = 1'b1;
                bus.wr_en = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FIFO_ARB_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if ((state_q == StFullWait) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
